// File: rtl/mem_arb_pkg.sv
// Shared constants for the IF/MEM memory-port arbiter: FSM state encoding,
// default bus widths and the performance-counter saturation value.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 32;

  localparam logic [CNT_W-1:0] SAT_MAX = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_IF_BUSY_ENC = 3'd1;
  localparam logic [2:0] ST_DM_BUSY_ENC = 3'd2;
  localparam logic [2:0] ST_IF_DONE_ENC = 3'd3;
  localparam logic [2:0] ST_DM_DONE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_IF_BUSY = ST_IF_BUSY_ENC,
    ST_DM_BUSY = ST_DM_BUSY_ENC,
    ST_IF_DONE = ST_IF_DONE_ENC,
    ST_DM_DONE = ST_DM_DONE_ENC
  } arb_state_t;

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating event counter used for the arbiter's stall statistics.
// Holds at SAT_MAX instead of wrapping.
module mem_arb_sat_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, sticking at the top value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != SAT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch (IF)
// and the load/store stage (DM). DM has priority because it holds the older
// instruction. A fetch can be killed on a redirect; it still finishes its
// memory handshake but produces no IFDone.
// Optional stall performance counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IFReq,
  input  logic [ADDR_W-1:0] IFAddr,
  input  logic              IFKill,
  input  logic              DMReq,
  input  logic              DMWrite,
  input  logic [ADDR_W-1:0] DMAddr,
  input  logic [DATA_W-1:0] DMWData,
  output logic              MemReq,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic              MemReady,
  input  logic [DATA_W-1:0] MemRData,
  output logic              IFDone,
  output logic [DATA_W-1:0] IFData,
  output logic              DMDone,
  output logic [DATA_W-1:0] DMData,
  output logic              IFStall,
  output logic              DMStall,
  output logic [CNT_W-1:0]  IFStallCycles,
  output logic [CNT_W-1:0]  DMStallCycles
);

  arb_state_t state;
  logic       kill;

  // In a DONE state the requester just served is ignored so its stale Req
  // cannot cause a second grant; only the other side may be granted.
  logic dm_grant;
  logic if_grant;

  assign dm_grant = DMReq && ((state == ST_IDLE) || (state == ST_IF_DONE));
  assign if_grant = IFReq && !dm_grant &&
                    ((state == ST_IDLE) || (state == ST_DM_DONE));

  assign IFStall = IFReq & ~IFDone;
  assign DMStall = DMReq & ~DMDone;

  // Arbiter FSM with registered memory-side and requester-side outputs.
  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      kill     <= 1'b0;
      MemReq   <= 1'b0;
      MemWE    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      IFDone   <= 1'b0;
      IFData   <= '0;
      DMDone   <= 1'b0;
      DMData   <= '0;
    end else begin
      IFDone <= 1'b0;
      DMDone <= 1'b0;
      case (state)
        ST_IDLE, ST_IF_DONE, ST_DM_DONE: begin
          if (dm_grant) begin
            MemReq   <= 1'b1;
            MemWE    <= DMWrite;
            MemAddr  <= DMAddr;
            MemWData <= DMWData;
            state    <= ST_DM_BUSY;
          end else if (if_grant) begin
            MemReq  <= 1'b1;
            MemWE   <= 1'b0;
            MemAddr <= IFAddr;
            kill    <= IFKill;
            state   <= ST_IF_BUSY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IF_BUSY: begin
          if (MemReady) begin
            MemReq <= 1'b0;
            MemWE  <= 1'b0;
            kill   <= 1'b0;
            if (kill || IFKill) begin
              state <= ST_IDLE;
            end else begin
              IFData <= MemRData;
              IFDone <= 1'b1;
              state  <= ST_IF_DONE;
            end
          end else if (IFKill) begin
            kill <= 1'b1;
          end
        end
        ST_DM_BUSY: begin
          if (MemReady) begin
            if (!MemWE) begin
              DMData <= MemRData;
            end
            DMDone <= 1'b1;
            MemReq <= 1'b0;
            MemWE  <= 1'b0;
            state  <= ST_DM_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_sat_cnt u_if_stall_cnt (
    .clk   (CLK),
    .rst   (Reset),
    .inc   (IFStall),
    .count (IFStallCycles)
  );

  mem_arb_sat_cnt u_dm_stall_cnt (
    .clk   (CLK),
    .rst   (Reset),
    .inc   (DMStall),
    .count (DMStallCycles)
  );
`else
  assign IFStallCycles = '0;
  assign DMStallCycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table (inputs
// driven on the falling edge, outputs sampled 1 ns later) plus hand-written
// sequences for asynchronous reset and the stall counters.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        dm_req;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_done;
  logic [31:0] if_data;
  logic        dm_done;
  logic [31:0] dm_data;
  logic        if_stall;
  logic        dm_stall;
  logic [31:0] if_stall_cycles;
  logic [31:0] dm_stall_cycles;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .CLK           (clk),
    .Reset         (rst),
    .IFReq         (if_req),
    .IFAddr        (if_addr),
    .IFKill        (if_kill),
    .DMReq         (dm_req),
    .DMWrite       (dm_write),
    .DMAddr        (dm_addr),
    .DMWData       (dm_wdata),
    .MemReq        (mem_req),
    .MemWE         (mem_we),
    .MemAddr       (mem_addr),
    .MemWData      (mem_wdata),
    .MemReady      (mem_ready),
    .MemRData      (mem_rdata),
    .IFDone        (if_done),
    .IFData        (if_data),
    .DMDone        (dm_done),
    .DMData        (dm_data),
    .IFStall       (if_stall),
    .DMStall       (dm_stall),
    .IFStallCycles (if_stall_cycles),
    .DMStallCycles (dm_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        dm_req;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_done;
    logic [31:0] e_if_data;
    logic        e_dm_done;
    logic [31:0] e_dm_data;
    logic        e_if_stall;
    logic        e_dm_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(
    input logic ifr, input logic [31:0] ifa, input logic ifk,
    input logic dmr, input logic dmw, input logic [31:0] dma, input logic [31:0] dmwd,
    input logic rdy, input logic [31:0] rd,
    input logic er, input logic ewe, input logic [31:0] ea, input logic [31:0] ewd,
    input logic eifd, input logic [31:0] eifdata,
    input logic edmd, input logic [31:0] edmdata,
    input logic eifs, input logic edms);
    vec_t v;
    v.if_req = ifr;  v.if_addr = ifa;  v.if_kill = ifk;
    v.dm_req = dmr;  v.dm_write = dmw; v.dm_addr = dma; v.dm_wdata = dmwd;
    v.mem_ready = rdy; v.mem_rdata = rd;
    v.e_req = er; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    v.e_if_done = eifd; v.e_if_data = eifdata;
    v.e_dm_done = edmd; v.e_dm_data = edmdata;
    v.e_if_stall = eifs; v.e_dm_stall = edms;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // IF only, 2 wait cycles
    add(1,'h40,0, 0,0,0,0, 0,0,            0,0,0,0,      0,0,           0,0, 1,0);
    add(1,'h40,0, 0,0,0,0, 0,0,            1,0,'h40,0,   0,0,           0,0, 1,0);
    add(1,'h40,0, 0,0,0,0, 0,0,            1,0,'h40,0,   0,0,           0,0, 1,0);
    add(1,'h40,0, 0,0,0,0, 1,'h8C220004,   1,0,'h40,0,   0,0,           0,0, 1,0);
    add(1,'h40,0, 0,0,0,0, 0,0,            0,0,0,0,      1,'h8C220004,  0,0, 0,0);
    add(0,0,0,    0,0,0,0, 0,0,            0,0,0,0,      0,'h8C220004,  0,0, 0,0);
    // simultaneous IF + DM store, zero wait; store must not touch DMData
    add(1,'h48,0, 1,1,'h100,'hDEADBEEF, 0,0,          0,0,0,0,                0,'h8C220004, 0,0, 1,1);
    add(1,'h48,0, 1,1,'h100,'hDEADBEEF, 1,'h55555555, 1,1,'h100,'hDEADBEEF,   0,'h8C220004, 0,0, 1,1);
    add(1,'h48,0, 1,1,'h100,'hDEADBEEF, 0,0,          0,0,0,0,                0,'h8C220004, 1,0, 1,0);
    add(1,'h48,0, 0,0,0,0,              1,'h13,       1,0,'h48,0,             0,'h8C220004, 0,0, 1,0);
    add(1,'h48,0, 0,0,0,0,              0,0,          0,0,0,0,                1,'h13,       0,0, 0,0);
    add(0,0,0,    0,0,0,0,              0,0,          0,0,0,0,                0,'h13,       0,0, 0,0);
    // killed fetch at 0x44, then redirected fetch at 0x80
    add(1,'h44,0, 0,0,0,0, 0,0,            0,0,0,0,     0,'h13,        0,0, 1,0);
    add(1,'h44,1, 0,0,0,0, 0,0,            1,0,'h44,0,  0,'h13,        0,0, 1,0);
    add(1,'h80,0, 0,0,0,0, 1,'h12345678,   1,0,'h44,0,  0,'h13,        0,0, 1,0);
    add(1,'h80,0, 0,0,0,0, 0,0,            0,0,0,0,     0,'h13,        0,0, 1,0);
    add(1,'h80,0, 0,0,0,0, 1,'hAABBCCDD,   1,0,'h80,0,  0,'h13,        0,0, 1,0);
    add(1,'h80,0, 0,0,0,0, 0,0,            0,0,0,0,     1,'hAABBCCDD,  0,0, 0,0);
    add(0,0,1,    0,0,0,0, 0,0,            0,0,0,0,     0,'hAABBCCDD,  0,0, 0,0);
    // back-to-back loads, 1 wait; stray MemReady in IDLE ignored
    add(0,0,0, 1,0,'h10,0, 0,0,            0,0,0,0,     0,'hAABBCCDD, 0,0,           0,1);
    add(0,0,0, 1,0,'h10,0, 0,0,            1,0,'h10,0,  0,'hAABBCCDD, 0,0,           0,1);
    add(0,0,0, 1,0,'h10,0, 1,'h11111111,   1,0,'h10,0,  0,'hAABBCCDD, 0,0,           0,1);
    add(0,0,0, 1,0,'h10,0, 0,0,            0,0,0,0,     0,'hAABBCCDD, 1,'h11111111,  0,0);
    add(0,0,0, 1,0,'h14,0, 1,'h99999999,   0,0,0,0,     0,'hAABBCCDD, 0,'h11111111,  0,1);
    add(0,0,0, 1,0,'h14,0, 0,0,            1,0,'h14,0,  0,'hAABBCCDD, 0,'h11111111,  0,1);
    add(0,0,0, 1,0,'h14,0, 1,'h22222222,   1,0,'h14,0,  0,'hAABBCCDD, 0,'h11111111,  0,1);
    add(0,0,0, 1,0,'h14,0, 0,0,            0,0,0,0,     0,'hAABBCCDD, 1,'h22222222,  0,0);
    add(0,0,0, 0,0,0,0,    0,0,            0,0,0,0,     0,'hAABBCCDD, 0,'h22222222,  0,0);

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_mem_req", 32'(mem_req), 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_if_data", if_data, 0);
    check("reset_dm_data", dm_data, 0);
    check("reset_if_cnt", if_stall_cycles, 0);
    check("reset_dm_cnt", dm_stall_cycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      if_req = vecs[i].if_req;  if_addr = vecs[i].if_addr; if_kill = vecs[i].if_kill;
      dm_req = vecs[i].dm_req;  dm_write = vecs[i].dm_write;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      mem_ready = vecs[i].mem_ready; mem_rdata = vecs[i].mem_rdata;
      #1;
      check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
        check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
        if (vecs[i].e_we)
          check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      end
      check($sformatf("v%0d if_done", i), 32'(if_done), 32'(vecs[i].e_if_done));
      check($sformatf("v%0d if_data", i), if_data, vecs[i].e_if_data);
      check($sformatf("v%0d dm_done", i), 32'(dm_done), 32'(vecs[i].e_dm_done));
      check($sformatf("v%0d dm_data", i), dm_data, vecs[i].e_dm_data);
      check($sformatf("v%0d if_stall", i), 32'(if_stall), 32'(vecs[i].e_if_stall));
      check($sformatf("v%0d dm_stall", i), 32'(dm_stall), 32'(vecs[i].e_dm_stall));
      @(negedge clk);
    end
    idle_inputs();

    // reset in the middle of DM_BUSY, then a late MemReady
    dm_req = 1'b1; dm_addr = 'h300;
    @(negedge clk);
    #1;
    check("rst_pre_mem_req", 32'(mem_req), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 0);
    check("rst_async_dm_data", dm_data, 0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1; mem_rdata = 'h77777777;
    @(negedge clk);
    #1;
    check("rst_late_ready_dm_done", 32'(dm_done), 0);
    check("rst_late_ready_mem_req", 32'(mem_req), 0);
    check("rst_late_ready_dm_data", dm_data, 0);
    mem_rdata = 'hCAFE0200;
    dm_req = 1'b1; dm_addr = 'h200;
    @(negedge clk);
    #1;
    check("rst_new_mem_req", 32'(mem_req), 1);
    check("rst_new_mem_addr", mem_addr, 'h200);
    @(negedge clk);
    #1;
    check("rst_new_dm_done", 32'(dm_done), 1);
    check("rst_new_dm_data", dm_data, 'hCAFE0200);
    idle_inputs();
    @(negedge clk);

    // stall counters: 5 stalled IF cycles (3 wait states)
    rst = 1'b1;
    #1;
    check("perf_clear_if", if_stall_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 'h60;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 'h0BADF00D;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("perf_if_done", 32'(if_done), 1);
    check("perf_if_data", if_data, 'h0BADF00D);
`ifdef MEM_ARB_PERF_EN
    check("perf_if_cnt", if_stall_cycles, 5);
`else
    check("perf_if_cnt", if_stall_cycles, 0);
`endif
    check("perf_dm_cnt", dm_stall_cycles, 0);
    if_req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
